score_bcd_scan: RTL
===================

// Module: score_bcd_scan
// PURPOSE
//   Upstream feeder for the 4-digit hex-to-7-segment decoder.
//   - Converts a binary score to 4 BCD digits (iterative double-dabble).
//   - Time-multiplexes the digits onto one 4-bit nibble bus plus active-low anode selects.
//   - digit_val drives the decoder input; an drives the display anodes directly.
// PARAMETERS
//   SCORE_W   14      width of binary score input (9999 fits in 14 bits)
//   SCAN_DIV  100000  clk cycles each digit stays lit; legal range >= 1
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        asynchronous, active-high reset
//   score        in   SCORE_W  binary score, sampled only when score_valid=1 and busy=0
//   score_valid  in   1        single-cycle load strobe
//   busy         out  1        conversion in progress; new loads ignored
//   conv_done    out  1        1-cycle pulse when display register is updated
//   digit_val    out  4        BCD nibble of currently selected digit, to decoder
//   an           out  4        anode enables, active-low; an[0] = ones digit
// BEHAVIOUR
//   Reset values: busy=0, conv_done=0, digit_val=4'h0, an=4'b1111,
//     display reg=16'h0000, scan idx=0, divider=0, FSM=IDLE.
//   FSM states: IDLE -> SHIFT -> LATCH -> IDLE.
//   - IDLE: score_valid=1 -> capture sat(score) into shift reg, clear BCD work reg,
//     bit cnt=0, go SHIFT. sat(x) = (x > 9999) ? 9999 : x.
//   - SHIFT: one bit per cycle, SCORE_W cycles total.
//     Each BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1.
//     After cnt = SCORE_W-1, go LATCH.
//   - LATCH: copy work reg to display reg; conv_done=1 for exactly this cycle; go IDLE.
//   busy=1 in SHIFT and LATCH.
//   Latency: strobe at edge 0 -> display reg and conv_done at edge SCORE_W+1
//     (15 with default width); busy drops on the following edge.
//   score_valid while busy (including the LATCH cycle): ignored, no queueing.
//   Reset mid-conversion: abort immediately; display reg returns to 0000.
//   Scan divider:
//   - divider counts 0..SCAN_DIV-1 and wraps.
//   - On the terminal count, idx advances 0->1->2->3->0.
//   - SCAN_DIV=1 advances idx every cycle.
//   Outputs are registered: each edge, an <= ~(4'b0001 << idx) and
//     digit_val <= display[4*idx +: 4]. Outputs therefore lag idx and display by 1 cycle.
//   Display update mid-scan: the lit digit shows the new value 1 cycle after LATCH;
//     no blanking gap and no idx reset.
//   At most one an bit is low at any time; no overlap between digits.
// CONFIGURATION
//   `LEADING_ZERO_BLANK_EN defined:
//   - An anode for idx>0 stays 1 (digit dark) when that digit and every higher digit are 0.
//   - Ones digit is always lit. digit_val is still driven normally.
//   - Example: 0007 lights only an[0].
//   Not defined: all four digits always lit, so 0007 displays "0007".
// TESTING  (bench uses SCAN_DIV=4)
//   1. Assert rst -> an=1111, digit_val=0, busy=0 immediately; after release, each
//      digit shows 0 as an sweeps 1110,1101,1011,0111.
//   2. score=1234, score_valid for 1 cycle -> busy high; conv_done pulses at edge 15;
//      then an=1110/dv=4, 1101/3, 1011/2, 0111/1, each held 4 cycles.
//   3. score=12000 -> after conversion, digits read 9,9,9,9 (saturation).
//   4. Load 1234, then score=42 with score_valid at edge 5 -> ignored;
//      display 1234, one conv_done only.
//   5. Macro on, score=7 -> an[3:1] never low, an[0] low 4 of every 16 cycles
//      with dv=7. Macro off -> digits 0,0,0,7 all lit.
//   6. Assert rst at edge 8 of a 9999 conversion -> busy=0 and an=1111 at once;
//      display shows 0000 after release; no conv_done.

Source files
------------

// File: rtl/score_bcd_scan.sv
// -----------------------------------------------------------------------------
// score_bcd_scan
//
// Purpose:
//   Upstream feeder for a 4-digit hex-to-7-segment decoder. Converts a binary
//   score (saturated to 9999) into four BCD digits using an iterative
//   double-dabble engine, one bit per clock. It then time-multiplexes those
//   digits onto a single nibble bus with active-low anode selects.
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   score        in   SCORE_W  binary score, taken on score_valid while not busy
//   score_valid  in   1        single-cycle load strobe
//   busy         out  1        conversion in progress; loads are ignored
//   conv_done    out  1        1-cycle pulse when the display register updates
//   digit_val    out  4        BCD nibble of the currently lit digit
//   an           out  4        anode enables, active-low, an[0] = ones digit
//
// Parameters:
//   SCORE_W   width of the binary score input
//   SCAN_DIV  clk cycles each digit stays lit (>= 1)
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are kept dark.
//                          The ones digit is always lit.
// -----------------------------------------------------------------------------
module score_bcd_scan #(
  parameter int SCORE_W  = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               conv_done,
  output logic [3:0]         digit_val,
  output logic [3:0]         an
);

  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } convState_t;

  convState_t         stateReg, stateNext;
  logic [SCORE_W-1:0] shiftReg, shiftNext;
  logic [15:0]        bcdReg, bcdNext;
  logic [15:0]        bcdAdj;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic [15:0]        displayReg, displayNext;
  logic               convDoneReg, convDoneNext;
  logic [SCORE_W-1:0] satScore;
  logic               loadOk;

  logic [DIV_W-1:0]   divReg;
  logic [1:0]         idxReg;
  logic [3:0]         digitArr [4];
  logic [3:0]         anNext;
  logic [3:0]         anReg;
  logic [3:0]         digitValReg;

  // Clamp to the largest value four BCD digits can show.
  assign satScore = (32'(score) > 32'd9999) ? SCORE_W'(9999) : score;

  // busy also covers the cycle in which conv_done is high, so a strobe
  // arriving right as the display updates is still rejected.
  assign busy      = (stateReg != IDLE) || convDoneReg;
  assign conv_done = convDoneReg;
  assign loadOk    = score_valid && (stateReg == IDLE) && !convDoneReg;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gAdj
      assign bcdAdj[4*gi +: 4] = (bcdReg[4*gi +: 4] >= 4'd5) ?
                                 (bcdReg[4*gi +: 4] + 4'd3) : bcdReg[4*gi +: 4];
      assign digitArr[gi]      = displayReg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    stateNext    = stateReg;
    shiftNext    = shiftReg;
    bcdNext      = bcdReg;
    cntNext      = cntReg;
    displayNext  = displayReg;
    convDoneNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (loadOk) begin
          shiftNext = satScore;
          bcdNext   = 16'h0000;
          cntNext   = '0;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        bcdNext   = {bcdAdj[14:0], shiftReg[SCORE_W-1]};
        shiftNext = shiftReg << 1;
        cntNext   = cntReg + CNT_W'(1);
        if (cntReg == LAST_BIT) begin
          stateNext = LATCH;
        end
      end
      LATCH: begin
        displayNext  = bcdReg;
        convDoneNext = 1'b1;
        stateNext    = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= IDLE;
      shiftReg    <= '0;
      bcdReg      <= 16'h0000;
      cntReg      <= '0;
      displayReg  <= 16'h0000;
      convDoneReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      shiftReg    <= shiftNext;
      bcdReg      <= bcdNext;
      cntReg      <= cntNext;
      displayReg  <= displayNext;
      convDoneReg <= convDoneNext;
    end
  end

  // Scan divider and digit index; the index free-runs and is never reset by
  // a display update, so a new value simply appears on the lit digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divReg <= '0;
      idxReg <= 2'd0;
    end else if (divReg == DIV_LAST) begin
      divReg <= '0;
      idxReg <= idxReg + 2'd1;
    end else begin
      divReg <= divReg + DIV_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // litMask[n] is high when digit n or any digit above it is non-zero.
  logic [3:0] litMask;
  assign litMask[0] = 1'b1;
  generate
    for (gi = 1; gi < 4; gi++) begin : gLit
      assign litMask[gi] = |displayReg[15:4*gi];
    end
  endgenerate
  assign anNext = ~(4'b0001 << idxReg) | ~litMask;
`else
  assign anNext = ~(4'b0001 << idxReg);
`endif

  // One-hot-low anode select makes digit overlap impossible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anReg       <= 4'b1111;
      digitValReg <= 4'h0;
    end else begin
      anReg       <= anNext;
      digitValReg <= digitArr[idxReg];
    end
  end

  assign an        = anReg;
  assign digit_val = digitValReg;

endmodule
